// File: rtl/mem_stage_lsu.sv
// Load/store stage between EX and WB.
// Runs one stb/ack bus cycle per memory op and emits one write-back beat per op.
module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int PC_INC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_result,
  input  logic [31:0]       i_data_store,
  input  logic [31:0]       i_pc,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func3,
  output logic              o_wb_valid,
  output logic [31:0]       o_wb_data,
  output logic [6:0]        o_opcode,
  output logic              o_misalign,
  output logic              o_bus_err,
  input  logic              i_rd_ack,
  input  logic [31:0]       i_read_data,
  output logic              o_stb,
  output logic              o_wr_en,
  output logic [3:0]        o_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wr_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;

  typedef enum logic {IDLE, BUS} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [6:0]        opc_q;
  logic              wb_valid_q;
  logic [31:0]       wb_data_q;
  logic [6:0]        wb_opc_q;
  logic              misalign_q;
  logic              bus_err_q;
  logic              stb_q;
  logic              wr_en_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_data_q;

  logic        is_ld;
  logic        is_s;
  logic        is_link;
  logic [1:0]  off;
  logic        mis_d;
  logic [3:0]  sel_d;
  logic [31:0] wd_d;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic        accept;

  assign is_ld   = (i_opcode == OP_LD);
  assign is_s    = (i_opcode == OP_S);
  assign is_link = (i_opcode == OP_J) || (i_opcode == OP_JR);
  assign off     = i_result[1:0];
  assign o_ready = (state_q == IDLE);
  assign accept  = i_valid && o_ready;

  // Lane enables, store replication and alignment fault for the presented op
  always_comb begin
    sel_d = 4'b1111;
    wd_d  = i_data_store;
    mis_d = |off;
    unique case (i_func3[1:0])
      2'b00: begin
        sel_d = 4'b0001 << off;
        wd_d  = {4{i_data_store[7:0]}};
        mis_d = 1'b0;
      end
      2'b01: begin
        sel_d = 4'b0011 << off;
        wd_d  = {2{i_data_store[15:0]}};
        mis_d = off[0];
      end
      default: ;
    endcase
  end

  // Align the returned word and apply sign/zero extension for the load width
  always_comb begin
    shifted = i_read_data >> {off_q, 3'b000};
    ld_data = shifted;
    unique case (f3_q)
      3'b000: ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001: ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100: ld_data = {24'd0, shifted[7:0]};
      3'b101: ld_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  // Stage FSM: accept in IDLE, hold the bus in BUS, register every output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      opc_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_opc_q   <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      stb_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if ((is_ld || is_s) && !mis_d) begin
              state_q   <= BUS;
              cnt_q     <= '0;
              f3_q      <= i_func3;
              off_q     <= off;
              opc_q     <= i_opcode;
              stb_q     <= is_ld;
              wr_en_q   <= is_s;
              sel_q     <= sel_d;
              addr_q    <= {i_result[ADDR_W-1:2], 2'b00};
              wr_data_q <= wd_d;
            end else begin
              wb_valid_q <= 1'b1;
              wb_opc_q   <= i_opcode;
              if (is_ld || is_s) begin
                misalign_q <= 1'b1;
                wb_data_q  <= '0;
              end else if (is_link) begin
                wb_data_q <= i_pc + 32'(PC_INC);
              end else begin
                wb_data_q <= i_result;
              end
            end
          end
        end
        BUS: begin
          if (i_rd_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stb_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wb_valid_q <= 1'b1;
            wb_opc_q   <= opc_q;
            bus_err_q  <= !i_rd_ack;
            wb_data_q  <= (i_rd_ack && opc_q == OP_LD) ? ld_data : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_valid = wb_valid_q;
  assign o_wb_data  = wb_data_q;
  assign o_opcode   = wb_opc_q;
  assign o_misalign = misalign_q;
  assign o_bus_err  = bus_err_q;
  assign o_stb      = stb_q;
  assign o_wr_en    = wr_en_q;
  assign o_sel      = sel_q;
  assign o_addr     = addr_q;
  assign o_wr_data  = wr_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu.
// Directed and random ops checked against an arithmetic reference model.
module tb_mem_stage_lsu;

  localparam int TO = 16;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_result;
  logic [31:0] i_data_store;
  logic [31:0] i_pc;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func3;
  logic        o_wb_valid;
  logic [31:0] o_wb_data;
  logic [6:0]  o_opcode;
  logic        o_misalign;
  logic        o_bus_err;
  logic        i_rd_ack;
  logic [31:0] i_read_data;
  logic        o_stb;
  logic        o_wr_en;
  logic [3:0]  o_sel;
  logic [31:0] o_addr;
  logic [31:0] o_wr_data;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(TO), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_result(i_result), .i_data_store(i_data_store),
    .i_pc(i_pc), .i_opcode(i_opcode), .i_func3(i_func3),
    .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
    .o_opcode(o_opcode), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err), .i_rd_ack(i_rd_ack),
    .i_read_data(i_read_data), .o_stb(o_stb),
    .o_wr_en(o_wr_en), .o_sel(o_sel), .o_addr(o_addr),
    .o_wr_data(o_wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Present one op, run its bus cycle (ack on BUS cycle k, k>TO = never),
  // and check everything against values derived from the ISA rules.
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] data,
                       input logic [31:0] pc, input logic [31:0] mem,
                       input int k);
    bit          is_ld, is_s, mis, signd;
    int          w, off;
    logic [3:0]  e_sel;
    logic [31:0] e_wd, e_ld, e_wb;
    longint      v;
    is_ld = (opc == LD);
    is_s  = (opc == ST);
    w     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(res % 4);
    mis   = (is_ld || is_s) && (off % w != 0);
    signd = (f3[2] == 1'b0) && (w < 4);
    e_sel = 4'd0;
    for (int i = 0; i < w; i++) if (off + i < 4) e_sel[off+i] = 1'b1;
    for (int ln = 0; ln < 4; ln++)
      e_wd[8*ln +: 8] = 8'((data >> (8 * (ln % w))) & 32'hFF);
    v = longint'((mem >> (8 * off))) & ((64'd1 << (8 * w)) - 1);
    if (signd && v >= (64'd1 << (8 * w - 1))) v = v - (64'd1 << (8 * w));
    e_ld = 32'(v);
    i_valid = 1'b1; i_opcode = opc; i_func3 = f3;
    i_result = res; i_data_store = data; i_pc = pc;
    chk("ready_idle", {31'd0, o_ready}, 32'd1);
    step();
    i_valid = 1'b0;
    if (!(is_ld || is_s) || mis) begin
      if (mis) e_wb = 32'd0;
      else if (opc == JAL || opc == JR) e_wb = pc + 32'd4;
      else e_wb = res;
      chk("wb_valid", {31'd0, o_wb_valid}, 32'd1);
      chk("wb_data", o_wb_data, e_wb);
      chk("wb_opc", {25'd0, o_opcode}, {25'd0, opc});
      chk("misalign", {31'd0, o_misalign}, {31'd0, mis});
      chk("bus_err", {31'd0, o_bus_err}, 32'd0);
      chk("no_bus", {30'd0, o_stb, o_wr_en}, 32'd0);
    end else begin
      chk("stb", {31'd0, o_stb}, {31'd0, is_ld});
      chk("wr_en", {31'd0, o_wr_en}, {31'd0, is_s});
      chk("sel", {28'd0, o_sel}, {28'd0, e_sel});
      chk("addr", o_addr, res - 32'(off));
      if (is_s) chk("wr_data", o_wr_data, e_wd);
      chk("ready_bus", {31'd0, o_ready}, 32'd0);
      for (int c = 1; c <= TO; c++) begin
        i_rd_ack = (c == k);
        i_read_data = (c == k) ? mem : $urandom;
        step();
        i_rd_ack = 1'b0;
        if (c == k) begin
          chk("beat", {29'd0, o_wb_valid, o_misalign, o_bus_err}, 32'd4);
          chk("ld_data", o_wb_data, is_ld ? e_ld : 32'd0);
          chk("beat_opc", {25'd0, o_opcode}, {25'd0, opc});
          chk("ready_back", {31'd0, o_ready}, 32'd1);
          break;
        end else if (c == TO) begin
          chk("to_beat", {29'd0, o_wb_valid, o_misalign, o_bus_err}, 32'd5);
          chk("to_data", o_wb_data, 32'd0);
          chk("to_stb", {30'd0, o_stb, o_wr_en}, 32'd0);
        end else begin
          chk("hold", {29'd0, o_stb, o_wr_en, o_wb_valid},
              {29'd0, is_ld, is_s, 1'b0});
        end
      end
    end
    step();
    chk("single_beat", {31'd0, o_wb_valid}, 32'd0);
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [2:0]  ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int          r;
    rst_n = 1'b0; i_valid = 1'b0; i_result = '0; i_data_store = '0;
    i_pc = '0; i_opcode = '0; i_func3 = '0; i_rd_ack = 1'b0;
    i_read_data = '0;
    step(); step();
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_outs", {27'd0, o_wb_valid, o_misalign, o_bus_err, o_stb,
        o_wr_en}, 32'd0);
    chk("rst_sel", {28'd0, o_sel}, 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    rst_n = 1'b1;
    step();

    do_op(LD, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h80FF_1234, 1);
    do_op(ST, 3'b001, 32'h2002, 32'hAAAA_BEEF, 32'd0, 32'd0, 1);
    do_op(LD, 3'b010, 32'h2001, 32'd0, 32'd0, 32'd0, 1);
    do_op(LD, 3'b010, 32'h5000, 32'd0, 32'd0, 32'h1111_2222, TO + 1);
    do_op(LD, 3'b010, 32'h5004, 32'd0, 32'd0, 32'h3333_4444, TO);
    do_op(JAL, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 1);
    do_op(JR, 3'b000, 32'd0, 32'd0, 32'h0000_1000, 32'd0, 1);
    do_op(ST, 3'b000, 32'h6001, 32'h0000_00A5, 32'd0, 32'd0, 3);
    do_op(LD, 3'b101, 32'h7002, 32'd0, 32'd0, 32'h8001_0000, 2);
    do_op(ST, 3'b010, 32'h8002, 32'h1, 32'd0, 32'd0, 1);

    // ack outside BUS does nothing
    i_rd_ack = 1'b1;
    step(); step();
    chk("idle_ack", {30'd0, o_wb_valid, o_ready}, 32'd1);
    i_rd_ack = 1'b0;

    // op held on i_valid while stalled is taken once the bus frees
    i_valid = 1'b1; i_opcode = LD; i_func3 = 3'b010; i_result = 32'h3000;
    step();
    i_opcode = ALU; i_result = 32'h1234_5678;
    chk("stall_ready", {30'd0, o_ready, o_stb}, 32'd1);
    step();
    chk("stall1", {30'd0, o_ready, o_wb_valid}, 32'd0);
    step();
    chk("stall2", {30'd0, o_ready, o_wb_valid}, 32'd0);
    i_rd_ack = 1'b1; i_read_data = 32'hCAFE_0001;
    step();
    i_rd_ack = 1'b0;
    chk("held_ld", o_wb_data, 32'hCAFE_0001);
    chk("held_rdy", {30'd0, o_ready, o_wb_valid}, 32'd3);
    step();
    i_valid = 1'b0;
    chk("held_alu_v", {31'd0, o_wb_valid}, 32'd1);
    chk("held_alu", o_wb_data, 32'h1234_5678);
    step();
    chk("held_once", {31'd0, o_wb_valid}, 32'd0);

    // reset in the middle of a bus cycle
    i_valid = 1'b1; i_opcode = LD; i_func3 = 3'b010; i_result = 32'h4000;
    step();
    i_valid = 1'b0;
    chk("rb_stb", {31'd0, o_stb}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rb_drop", {29'd0, o_stb, o_wb_valid, o_ready}, 32'd1);
    rst_n = 1'b1;
    i_rd_ack = 1'b1;
    step();
    i_rd_ack = 1'b0;
    chk("rb_after", {29'd0, o_stb, o_wb_valid, o_ready}, 32'd1);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 4));
      opc = (r == 0) ? LD : (r == 1) ? ST : (r == 2) ? JAL :
            (r == 3) ? JR : ALU;
      f3 = (opc == LD) ? ldf[$urandom_range(0, 4)] :
                         3'($urandom_range(0, 2));
      do_op(opc, f3, $urandom, $urandom, $urandom, $urandom,
            int'($urandom_range(1, TO + 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
